// File: rtl/decimal_key_pkg.sv
// -----------------------------------------------------------------------------
// decimal_key_pkg
// Shared types and constants for the decimal key accumulator.
//   state_t     : accumulator FSM states
//   bcd_digit_t : one packed BCD digit
//   DIGIT_ERR   : code the key decoder returns when no key line is set
// -----------------------------------------------------------------------------
package decimal_key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      WAIT_RELEASE,
      HOLD
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Not a valid BCD digit, so it can never be mistaken for a real key.
   localparam bcd_digit_t DIGIT_ERR = 4'hF;

endpackage : decimal_key_pkg

// File: rtl/onehot10_to_bcd.sv
// -----------------------------------------------------------------------------
// onehot10_to_bcd
// Combinational decoder from ten one-hot key lines to a BCD digit.
// When several lines are set, the lowest-numbered one wins.
//   key       in  [9:0]  key lines, bit k = digit k
//   digit     out        BCD code of the winning line, DIGIT_ERR if none set
//   onehot_ok out        exactly one key line is set
// -----------------------------------------------------------------------------
module onehot10_to_bcd
   import decimal_key_pkg::*;
(
   input  logic [9:0] key,
   output bcd_digit_t digit,
   output logic       onehot_ok
);

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      digit = DIGIT_ERR;
      // Walk from the top down so the lowest set bit is the last assignment.
      for (int k = 9; k >= 0; k--) begin
         if (key[k]) digit = bcd_digit_t'(k);
      end
   end

   // x & (x-1) clears the lowest set bit; zero afterwards means one bit only.
   assign onehot_ok = (key != 10'd0) && ((key & (key - 10'd1)) == 10'd0);

endmodule : onehot10_to_bcd

// File: rtl/decimal_key_accumulator.sv
// -----------------------------------------------------------------------------
// decimal_key_accumulator
// Debounces a ten-key decimal keypad, shifts accepted digits into a packed BCD
// register and publishes the number with a valid/ready handshake.
//
// Parameters
//   DIGITS          BCD digits held (1..8)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a key (2..65535)
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   key_in   [9:0]  one-hot key lines, already synchronised to clk
//   enter           publish the accumulated number
//   clear           synchronous clear, overrides everything else
//   out_ready       consumer accepts bcd_out
//   bcd_out         packed BCD number, digit 0 in [3:0]
//   digit_count     number of digits entered
//   out_valid       bcd_out is published
//   overflow        sticky: a digit was dropped because the register was full
//   key_err         (only with MULTI_HOT_REJECT_EN) one-cycle pulse when a
//                   multi-hot key pattern is rejected
//
// Build option
//   MULTI_HOT_REJECT_EN  reject non-one-hot key patterns and add key_err;
//                        without it the lowest set key line wins.
// -----------------------------------------------------------------------------
module decimal_key_accumulator
   import decimal_key_pkg::*;
#(
   parameter int DIGITS          = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [9:0]                   key_in,
   input  logic                         enter,
   input  logic                         clear,
   input  logic                         out_ready,
   output logic [4*DIGITS-1:0]          bcd_out,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         out_valid,
   output logic                         overflow
`ifdef MULTI_HOT_REJECT_EN
   ,
   output logic                         key_err
`endif
);

   localparam int BW    = 4 * DIGITS;
   localparam int CW    = $clog2(DIGITS + 1);
   localparam int CNT_W = 16;

   localparam logic [CW-1:0]    FULL_COUNT = CW'(DIGITS);
   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_CYCLES);

   state_t             state_q, state_d;
   logic [9:0]         pat_q, pat_d;
   bcd_digit_t         code_q, code_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic [CW-1:0]      count_q, count_d;
   logic               ovf_q, ovf_d;

   bcd_digit_t         key_digit;
   logic               onehot_ok;
   logic               key_ok;
   logic               key_reject;
   logic [CNT_W-1:0]   cnt_inc;

   onehot10_to_bcd u_decode (
      .key       (key_in),
      .digit     (key_digit),
      .onehot_ok (onehot_ok)
   );

`ifdef MULTI_HOT_REJECT_EN
   assign key_ok = onehot_ok;
`else
   // Any nonzero pattern is usable; the decoder already picks the lowest line.
   assign key_ok = 1'b1;
   logic unused_onehot_ok;
   assign unused_onehot_ok = onehot_ok;
`endif

   // Never overflows: cnt_q stays below DEBOUNCE_CYCLES while debouncing.
   assign cnt_inc = cnt_q + CNT_W'(1);

   // ---------------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      code_d     = code_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      key_reject = 1'b0;

      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         bcd_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enter && (count_q != '0)) begin
                  state_d = HOLD;
               end else if (key_in != 10'd0) begin
                  if (key_ok) begin
                     // The capture cycle is the first stable cycle.
                     pat_d   = key_in;
                     code_d  = key_digit;
                     cnt_d   = CNT_W'(1);
                     state_d = DEBOUNCE;
                  end else begin
                     key_reject = 1'b1;
                  end
               end
            end

            DEBOUNCE: begin
               if (key_in == pat_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == STABLE_MAX) begin
                     state_d = WAIT_RELEASE;
                     if (count_q == FULL_COUNT) begin
                        ovf_d = 1'b1;
                     end else begin
                        bcd_d   = (bcd_q << 4) | BW'(code_q);
                        count_d = count_q + CW'(1);
                     end
                  end
               end else begin
                  state_d = IDLE;
               end
            end

            WAIT_RELEASE: begin
               if (key_in == 10'd0) state_d = IDLE;
            end

            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
                  bcd_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         code_q  <= DIGIT_ERR;
         cnt_q   <= '0;
         bcd_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef MULTI_HOT_REJECT_EN
   // Pulse once per rejected press rather than every cycle it is held.
   logic reject_seen_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reject_seen_q <= 1'b0;
         key_err       <= 1'b0;
      end else begin
         reject_seen_q <= key_reject;
         key_err       <= key_reject && !reject_seen_q;
      end
   end
`else
   logic unused_key_reject;
   assign unused_key_reject = key_reject;
`endif

   assign bcd_out     = bcd_q;
   assign digit_count = count_q;
   assign overflow    = ovf_q;
   // Valid is exactly "number is being offered", i.e. the HOLD state.
   assign out_valid   = (state_q == HOLD);

endmodule : decimal_key_accumulator
